uart_rx: RTL and testbench

//  8N1 UART receiver, oversampled; the serial-input front end of the tt_um_njzhu_uart top.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
// The future uart_tx uses the same divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV enabled clocks.
// clr restarts the count so ticks stay aligned to the frame's start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 65
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == CW'(DIV - 1)) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with a one-entry valid/ready holding register.
// Reports framing errors and overruns as single-clock pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 10_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int          OS_W = $clog2(OVERSAMPLE);
  localparam int          BC_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] SAMP0 = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP1 = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SAMP2 = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] TLAST = OS_W'(OVERSAMPLE - 1);

  rx_state_e            state;
  logic                 rx_meta, rx_s, rx_prev;
  logic [OS_W-1:0]      tick_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;
  logic                 baud_clr, tick, mid, maj;

  // Ticks run only while a frame is in flight, so sampling phase follows the start edge.
  assign baud_clr = (state == IDLE) || (state == BREAK);
  assign mid      = tick && (tick_cnt == SAMP2);
  assign maj      = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .en    (!baud_clr),
    .tick  (tick)
  );

  // Resets to the idle-high level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      samp0       <= 1'b0;
      samp1       <= 1'b0;
      shift       <= '0;
      deliver     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      deliver     <= 1'b0;
      frame_err_o <= 1'b0;
      if (tick) begin
        tick_cnt <= (tick_cnt == TLAST) ? '0 : tick_cnt + OS_W'(1);
        if (tick_cnt == SAMP0) samp0 <= rx_s;
        if (tick_cnt == SAMP1) samp1 <= rx_s;
      end
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (mid) begin
            if (!maj) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shift <= {maj, shift[DATA_BITS-1:1]};
            if (bit_cnt == BC_W'(DATA_BITS - 1)) state <= STOP;
            else bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        STOP: begin
          // Returning to IDLE at mid-stop lets the next start edge be seen immediately.
          if (mid) begin
            if (maj) begin
              deliver <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          tick_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A consume in the delivery cycle frees the holding register for the new byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (deliver) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= shift;
          rx_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, scaled to a 7-clock tick (112 clocks per bit).
// A negedge monitor counts handshakes and pulses; the main sequence compares against hand-computed values.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 9600;
  localparam int unsigned OS     = 16;
  localparam int          DIV    = 7;          // round(1e6 / 153600) = round(6.51)
  localparam int          BIT    = DIV * 16;
  // Drive-to-valid: 2 sync clks + edge register, 1 clk counter restart, 154 ticks to
  // the stop-bit decision (tick 9 of bit 9), tick register, FSM edge, holding register.
  localparam int          VALID_LAT = 5 + 154 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_acc = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, rise_cyc = 0;
  logic [7:0] last_acc = 8'h00;
  logic prev_valid = 1'b0;
  int a0, v0, f0, o0;

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid_o === 1'b1 && rx_ready_i === 1'b1) begin
      n_acc++;
      last_acc = rx_data_o;
    end
    if (rx_valid_o === 1'b1) n_vcyc++;
    if (rx_valid_o === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = rx_valid_o;
    if (frame_err_o === 1'b1) n_ferr++;
    if (overrun_o === 1'b1) n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    a0 = n_acc;
    v0 = n_vcyc;
    f0 = n_ferr;
    o0 = n_ovr;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    rx_i = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clks(BIT);
    end
    rx_i = stop;
    wait_clks(BIT);
    rx_i = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;
    wait_clks(3);
    check("reset_data", 32'(rx_data_o), 32'h00);
    check("reset_valid", 32'(rx_valid_o), 32'h0);
    check("reset_ferr", 32'(frame_err_o), 32'h0);
    check("reset_ovr", 32'(overrun_o), 32'h0);
    rst_n = 1'b1;
    wait_clks(BIT);

    // 1: single byte, consumer always ready.
    rx_ready_i = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1);
    wait_clks(BIT);
    check("t1_accepts", 32'(n_acc - a0), 32'd1);
    check("t1_data", 32'(last_acc), 32'hA5);
    check("t1_valid_cycles", 32'(n_vcyc - v0), 32'd1);
    check("t1_latency", 32'(rise_cyc - start_cyc), 32'(VALID_LAT));
    check("t1_ferr", 32'(n_ferr - f0), 32'd0);
    check("t1_ovr", 32'(n_ovr - o0), 32'd0);

    // 2: three-tick glitch is rejected, next frame still decodes.
    snap();
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    wait_clks(3 * DIV);
    rx_i = 1'b1;
    wait_clks(2 * BIT);
    check("t2_glitch_valid", 32'(n_vcyc - v0), 32'd0);
    check("t2_glitch_ferr", 32'(n_ferr - f0), 32'd0);
    snap();
    send_frame(8'h5A, 1'b1);
    wait_clks(BIT);
    check("t2_accepts", 32'(n_acc - a0), 32'd1);
    check("t2_data", 32'(last_acc), 32'h5A);

    // 3: bad stop bit followed by a held-low line.
    snap();
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b0;
    wait_clks(20 * BIT);
    check("t3_ferr_pulses", 32'(n_ferr - f0), 32'd1);
    check("t3_valid_cycles", 32'(n_vcyc - v0), 32'd0);
    check("t3_ovr", 32'(n_ovr - o0), 32'd0);
    rx_i = 1'b1;
    wait_clks(2 * BIT);
    snap();
    send_frame(8'hC3, 1'b1);
    wait_clks(BIT);
    check("t3_accepts", 32'(n_acc - a0), 32'd1);
    check("t3_data", 32'(last_acc), 32'hC3);

    // 4: consumer stalled across two bytes; second byte overruns.
    rx_ready_i = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    wait_clks(BIT);
    send_frame(8'h22, 1'b1);
    wait_clks(BIT);
    check("t4_ovr_pulses", 32'(n_ovr - o0), 32'd1);
    check("t4_valid_held", 32'(rx_valid_o), 32'h1);
    check("t4_data_held", 32'(rx_data_o), 32'h11);
    check("t4_no_accept", 32'(n_acc - a0), 32'd0);
    rx_ready_i = 1'b1;
    wait_clks(1);
    rx_ready_i = 1'b0;
    check("t4_valid_dropped", 32'(rx_valid_o), 32'h0);
    check("t4_accept_data", 32'(last_acc), 32'h11);
    check("t4_ferr", 32'(n_ferr - f0), 32'd0);

    // 5: ready pulsed exactly in the delivery cycle of the second byte.
    snap();
    send_frame(8'h11, 1'b1);
    wait_clks(BIT);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (VALID_LAT - 1) @(posedge clk);
        #1;
        rx_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rx_ready_i = 1'b0;
      end
    join
    wait_clks(BIT);
    check("t5_ovr", 32'(n_ovr - o0), 32'd0);
    check("t5_accepts", 32'(n_acc - a0), 32'd1);
    check("t5_accept_data", 32'(last_acc), 32'h11);
    check("t5_valid", 32'(rx_valid_o), 32'h1);
    check("t5_data", 32'(rx_data_o), 32'h22);

    // 6: reset pulse during data bit 4 abandons the frame and clears the outputs.
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    wait_clks(5 * BIT);
    rx_i = 1'b1;
    wait_clks(BIT / 2);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    check("t6_reset_data", 32'(rx_data_o), 32'h00);
    check("t6_reset_valid", 32'(rx_valid_o), 32'h0);
    check("t6_reset_ferr", 32'(frame_err_o), 32'h0);
    check("t6_reset_ovr", 32'(overrun_o), 32'h0);
    wait_clks(2 * BIT);
    rx_ready_i = 1'b1;
    snap();
    send_frame(8'hFF, 1'b1);
    wait_clks(BIT);
    check("t6_accepts", 32'(n_acc - a0), 32'd1);
    check("t6_data", 32'(last_acc), 32'hFF);
    check("t6_ferr", 32'(n_ferr - f0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
